// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared defaults and FSM encoding for the instruction fetch queue
package riscv_fetch_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry synchronous FIFO holding {pc, word} pairs
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - fetch PC, request credit gating and redirect flush in front of the core
module instr_fetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH+1);

    fetch_state_t      state, state_next;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   resp_pc;
    logic [XLEN-1:0]   target;
    logic [CW-1:0]     outstanding, outstanding_next;
    logic [CW-1:0]     stale, stale_next;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       occupancy;
    logic [2*XLEN-1:0] fifo_head;
    logic              grant;
    logic              push;
    logic              pop;
    logic              has_entry;

    assign target    = redirect_pc & ~XLEN'(3);
    assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count};

    // Buffered plus in-flight words never exceed DEPTH, so a response always has a FIFO slot.
    assign imem_req  = !reset && (state == FETCH) && !redirect && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    assign push      = (state == FETCH) && !redirect && imem_rvalid && (outstanding != '0);
    assign has_entry = (fifo_count != '0);
    assign pop       = has_entry && instr_ready && !redirect;

    assign instr_valid = has_entry;
    assign instr       = has_entry ? fifo_head[XLEN-1:0]      : '0;
    assign instr_pc    = has_entry ? fifo_head[2*XLEN-1:XLEN] : '0;

    always_comb begin
        state_next       = state;
        outstanding_next = outstanding;
        stale_next       = stale;
        case (state)
            FETCH: begin
                if (redirect) begin
                    // The same-cycle response belongs to the old stream and is dropped here.
                    stale_next       = outstanding - CW'(imem_rvalid && (outstanding != '0));
                    outstanding_next = '0;
                    state_next       = (stale_next == '0) ? FETCH : FLUSH;
                end else begin
                    outstanding_next = outstanding + CW'(grant) - CW'(push);
                    stale_next       = '0;
                end
            end
            FLUSH: begin
                stale_next       = stale - CW'(imem_rvalid && (stale != '0));
                outstanding_next = '0;
                state_next       = (stale_next == '0) ? FETCH : FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            outstanding <= '0;
            stale       <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            stale       <= stale_next;
        end
    end

    // resp_pc tracks the PC of the next accepted response; requests are sequential so it trails fetch_pc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= target;
            resp_pc  <= target;
        end else begin
            if (grant) fetch_pc <= fetch_pc + XLEN'(4);
            if (push)  resp_pc  <= resp_pc + XLEN'(4);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({resp_pc, imem_rdata}),
        .pop       (pop),
        .flush     (redirect),
        .count     (fifo_count),
        .head      (fifo_head)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - table-driven and scoreboard bench for instr_fetch_queue
module tb_instr_fetch_queue;
    import riscv_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_stall;

    instr_fetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] pend_q[$];
    logic        g_neg = 1'b0;
    logic [31:0] a_neg = '0;

    // Scoreboard: expected deliveries are queued at grant time and popped on each consumed instruction.
    initial forever begin
        @(negedge clk or posedge reset);
        if (reset) begin
            exp_q.delete();
            g_neg = 1'b0;
        end else begin
            assert (!(imem_rvalid && dut.state == FETCH && dut.outstanding == '0))
                else $error("protocol: rvalid with nothing outstanding");
            if (redirect) begin
                exp_q.delete();
            end else if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got pc %h, expected no delivery", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", instr_pc, e.pc);
                    check("sb_instr", instr, e.word);
                end
            end
            g_neg = imem_req && imem_gnt;
            a_neg = imem_addr;
            if (g_neg) exp_q.push_back('{imem_addr, word_of(imem_addr)});
        end
    end

    // In-order memory: a grant is answered in the next cycle unless mem_stall holds it back.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            pend_q.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end else begin
            if (g_neg) pend_q.push_back(a_neg);
            #2;
            if (!reset) begin
                if (pend_q.size() != 0 && !mem_stall) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word_of(pend_q.pop_front());
                end else begin
                    imem_rvalid = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic ready;
        logic gnt;
        int   cycles;
        int   exp_grants;
        logic exp_req;
        logic exp_valid;
    } row_t;

    row_t rows[6];
    int   grants;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        imem_gnt    = 1'b0;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        mem_stall   = 1'b0;
        repeat (6) next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rows[0] = '{1'b1, 1'b0, 4, 0, 1'b1, 1'b0};
        rows[1] = '{1'b0, 1'b1, 8, 4, 1'b0, 1'b1};
        rows[2] = '{1'b1, 1'b1, 1, 0, 1'b0, 1'b1};
        rows[3] = '{1'b0, 1'b1, 3, 1, 1'b0, 1'b1};
        rows[4] = '{1'b1, 1'b1, 8, 7, 1'b1, 1'b1};
        rows[5] = '{1'b1, 1'b0, 4, 0, 1'b1, 1'b0};

        imem_gnt    = 1'b1;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_stall   = 1'b0;
        #1 reset = 1'b1;

        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("first_req", 32'(imem_req), 32'h1);
                check("first_addr", imem_addr, 32'h0);
            end
            check("stream_valid", 32'(instr_valid), 32'(c >= 2));
            next_cycle();
        end

        for (int r = 0; r < 6; r++) begin
            imem_gnt    = rows[r].gnt;
            instr_ready = rows[r].ready;
            grants      = 0;
            for (int k = 0; k < rows[r].cycles; k++) begin
                @(negedge clk);
                if (imem_req && imem_gnt) grants++;
                if (k == rows[r].cycles - 1) begin
                    check("row_grants", 32'(grants), 32'(rows[r].exp_grants));
                    check("row_req", 32'(imem_req), 32'(rows[r].exp_req));
                    check("row_valid", 32'(instr_valid), 32'(rows[r].exp_valid));
                end
                next_cycle();
            end
        end

        // Redirect to 0x103 with two requests in flight.
        mem_stall = 1'b1;
        imem_gnt  = 1'b1;
        repeat (2) next_cycle();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        check("redir_req_masked", 32'(imem_req), 32'h0);
        next_cycle();
        redirect  = 1'b0;
        mem_stall = 1'b0;
        imem_gnt  = 1'b1;
        @(negedge clk);
        check("flush_req0", 32'(imem_req), 32'h0);
        check("flush_valid0", 32'(instr_valid), 32'h0);
        next_cycle();
        @(negedge clk);
        check("flush_req1", 32'(imem_req), 32'h0);
        next_cycle();
        @(negedge clk);
        check("target_req", 32'(imem_req), 32'h1);
        check("target_addr", imem_addr, 32'h0000_0100);
        repeat (2) next_cycle();
        @(negedge clk);
        check("target_valid", 32'(instr_valid), 32'h1);
        check("target_pc", instr_pc, 32'h0000_0100);
        repeat (4) next_cycle();
        drain();

        // Redirect coinciding with the only outstanding response.
        imem_gnt = 1'b1;
        next_cycle();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0180;
        next_cycle();
        redirect = 1'b0;
        imem_gnt = 1'b1;
        @(negedge clk);
        check("same_req", 32'(imem_req), 32'h1);
        check("same_addr", imem_addr, 32'h0000_0180);
        check("same_valid", 32'(instr_valid), 32'h0);
        repeat (2) next_cycle();
        @(negedge clk);
        check("same_pc", instr_pc, 32'h0000_0180);
        repeat (3) next_cycle();
        drain();

        // Second redirect while still flushing the first.
        mem_stall = 1'b1;
        imem_gnt  = 1'b1;
        repeat (2) next_cycle();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        next_cycle();
        redirect_pc = 32'h0000_0202;
        mem_stall   = 1'b0;
        @(negedge clk);
        check("flush2_req0", 32'(imem_req), 32'h0);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        check("flush2_req1", 32'(imem_req), 32'h0);
        next_cycle();
        imem_gnt = 1'b1;
        @(negedge clk);
        check("flush2_req", 32'(imem_req), 32'h1);
        check("flush2_addr", imem_addr, 32'h0000_0200);
        repeat (2) next_cycle();
        @(negedge clk);
        check("flush2_pc", instr_pc, 32'h0000_0200);
        repeat (4) next_cycle();

        // Asynchronous reset pulse in the middle of a cycle.
        #2 reset = 1'b1;
        #1;
        check("areset_req", 32'(imem_req), 32'h0);
        check("areset_addr", imem_addr, 32'h0);
        check("areset_valid", 32'(instr_valid), 32'h0);
        check("areset_instr", instr, 32'h0);
        check("areset_pc", instr_pc, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("restart_req", 32'(imem_req), 32'h1);
        check("restart_addr", imem_addr, 32'h0);
        repeat (2) next_cycle();
        @(negedge clk);
        check("restart_valid", 32'(instr_valid), 32'h1);
        check("restart_pc", instr_pc, 32'h0);
        repeat (4) next_cycle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
